// File: rtl/adder_rr_arbiter_if.sv
// adder_rr_arbiter_if
//   Bundles the request and response handshakes of adder_rr_arbiter.
//   Parameters: WIDTH (operand width), NREQ (number of requesters).
//   Signals:
//     req_valid/req_ready/req_sub [NREQ]  per-requester handshake and ADD/SUB select
//     req_a/req_b [NREQ*WIDTH]            operands, requester i at [i*WIDTH +: WIDTH]
//     resp_valid/resp_ready               response slot handshake
//     resp_id/resp_y/resp_carry           owner index, result, adder carry-out
//     resp_ovf                            signed overflow, present only with ADD_ARB_OVF_EN
//   Modports: master = requesters + consumer side, slave = arbiter side.
interface adder_rr_arbiter_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_sub;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_y;
    logic                  resp_carry;
`ifdef ADD_ARB_OVF_EN
    logic                  resp_ovf;
`endif

    modport master (
        output req_valid, req_sub, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_y, resp_carry
`ifdef ADD_ARB_OVF_EN
        , input resp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_y, resp_carry
`ifdef ADD_ARB_OVF_EN
        , output resp_ovf
`endif
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
//   Shares one Kogge-Stone adder between NREQ requesters. Round-robin grant,
//   valid/ready per request port, one registered response slot with backpressure.
//   Each request performs a+b or a-b (b inverted, carry_in=1).
// Ports:
//   clk  in   clock, all state on rising edge
//   rst  in   asynchronous active-high reset
//   bus  adder_rr_arbiter_if.slave (request/response handshakes, see interface file)
// Parameters: WIDTH (operand width), NREQ (requesters, >=2); IDW derived.
// Optional feature: define ADD_ARB_OVF_EN to add the registered resp_ovf output
// (signed overflow of the granted operation).
module adder_rr_arbiter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREQ  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_rr_arbiter_if.slave    bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    // One extra bit so ptr+offset can exceed NREQ-1 before the wrap subtract.
    localparam int unsigned CW  = IDW + 1;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_y_q, resp_y_d;
    logic             resp_carry_q, resp_carry_d;
`ifdef ADD_ARB_OVF_EN
    logic             resp_ovf_q, resp_ovf_d;
    logic             ovf;
`endif

    logic             accept;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic             xfer;
    logic [NREQ-1:0]  req_ready;
    logic [WIDTH-1:0] a_sel, b_sel, b_eff;
    logic             sub_sel;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    // Slot can take a new result when empty or being drained this cycle.
    // Held off during reset so no requester sees a handshake the flops would drop.
    assign accept = !rst && (!resp_valid_q || bus.resp_ready);
    assign xfer   = accept && gnt_found;

    // Round-robin search: ptr, ptr+1, ..., NREQ-1, 0, ...
    always_comb begin : grant
        logic [CW-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = {1'b0, ptr_q} + CW'(off);
            if (idx >= CW'(NREQ)) begin
                idx = idx - CW'(NREQ);
            end
            if (!gnt_found && bus.req_valid[idx[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end
    assign bus.req_ready = req_ready;

    // Operand mux to the shared adder.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel   = bus.req_a[i*WIDTH +: WIDTH];
                b_sel   = bus.req_b[i*WIDTH +: WIDTH];
                sub_sel = bus.req_sub[i];
            end
        end
    end

    assign b_eff = sub_sel ? ~b_sel : b_sel;

    // Kogge-Stone parallel prefix. Carry-in is folded into bit 0's generate so
    // g[i] after the last level is the carry out of bit i.
    always_comb begin : ks_adder
        logic [WIDTH-1:0] g, p, p0;
        p0 = a_sel ^ b_eff;
        p  = p0;
        g  = a_sel & b_eff;
        g[0] = g[0] | (p0[0] & sub_sel);
        for (int unsigned d = 1; d < WIDTH; d = d * 2) begin
            g = g | (p & (g << d));
            p = p & ((p << d) | ~({WIDTH{1'b1}} << d));
        end
        sum       = p0 ^ {g[WIDTH-2:0], sub_sel};
        carry_out = g[WIDTH-1];
    end

`ifdef ADD_ARB_OVF_EN
    assign ovf = (a_sel[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
`endif

    always_comb begin
        ptr_d        = ptr_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_y_d     = resp_y_q;
        resp_carry_d = resp_carry_q;
`ifdef ADD_ARB_OVF_EN
        resp_ovf_d   = resp_ovf_q;
`endif
        if (xfer) begin
            resp_valid_d = 1'b1;
            resp_id_d    = gnt_idx;
            resp_y_d     = sum;
            resp_carry_d = carry_out;
`ifdef ADD_ARB_OVF_EN
            resp_ovf_d   = ovf;
`endif
            ptr_d        = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_y_q     <= '0;
            resp_carry_q <= 1'b0;
`ifdef ADD_ARB_OVF_EN
            resp_ovf_q   <= 1'b0;
`endif
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_y_q     <= resp_y_d;
            resp_carry_q <= resp_carry_d;
`ifdef ADD_ARB_OVF_EN
            resp_ovf_q   <= resp_ovf_d;
`endif
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_y     = resp_y_q;
    assign bus.resp_carry = resp_carry_q;
`ifdef ADD_ARB_OVF_EN
    assign bus.resp_ovf   = resp_ovf_q;
`endif

endmodule
